// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: opcode constants, the bubble
// word, 2-bit branch counter encodings, fetch control states, the IF/ID
// register layout and the saturating counter update.
package fetch_stage_pkg;

  localparam logic [3:0]  OP_B        = 4'hC;
  localparam logic [3:0]  OP_BR       = 4'hD;
  localparam logic [3:0]  OP_HLT      = 4'hF;
  localparam logic [15:0] BUBBLE_INST = 16'h0000;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [15:0] pc_curr;
    logic [15:0] pc_next;
    logic [15:0] inst;
    logic        valid;
    logic        pred_taken;
    logic [15:0] pred_target;
  } ifid_t;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic logic [1:0] cnt_update(input logic [1:0] c, input logic taken);
    if (taken) return (c == CNT_ST)  ? c : c + 2'd1;
    else       return (c == CNT_SNT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus between fetch and its neighbours: instruction memory read port,
// decode's branch resolution feedback, hazard stall, and the IF/ID
// register outputs consumed by decode.
//   master : the fetch stage (drives imem_addr, IF_ID_*, halted)
//   slave  : memory/decode/hazard side
interface fetch_stage_if;
  logic        stall;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        ID_is_branch;
  logic        ID_branch_taken;
  logic        ID_branch_mispredicted;
  logic [15:0] ID_branch_target;
  logic [15:0] IF_ID_pc_curr;
  logic [15:0] IF_ID_pc_next;
  logic [15:0] IF_ID_inst;
  logic        IF_ID_valid;
  logic        IF_ID_predicted_taken;
  logic [15:0] IF_ID_predicted_target;
  logic        halted;

  modport master (
    input  stall, imem_rdata, ID_is_branch, ID_branch_taken,
           ID_branch_mispredicted, ID_branch_target,
    output imem_addr, IF_ID_pc_curr, IF_ID_pc_next, IF_ID_inst, IF_ID_valid,
           IF_ID_predicted_taken, IF_ID_predicted_target, halted
  );

  modport slave (
    output stall, imem_rdata, ID_is_branch, ID_branch_taken,
           ID_branch_mispredicted, ID_branch_target,
    input  imem_addr, IF_ID_pc_curr, IF_ID_pc_next, IF_ID_inst, IF_ID_valid,
           IF_ID_predicted_taken, IF_ID_predicted_target, halted
  );
endinterface

// File: rtl/fetch_stage_branch_predictor.sv
// Direct-mapped branch history / target table.
//   lookup_pc  : fetch PC (bit 0 dropped, always halfword aligned)
//   pred_*     : combinational prediction for lookup_pc
//   upd_*      : training port from decode, indexed by the IF/ID PC
// Reads see the pre-update contents when lookup and update share an index.
module branch_predictor
  import fetch_stage_pkg::*;
#(
  parameter int BHT_IDX_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:1] lookup_pc,
  output logic        pred_taken,
  output logic [15:0] pred_target,
  input  logic        upd_en,
  input  logic [15:1] upd_pc,
  input  logic        upd_taken,
  input  logic [15:0] upd_target
);
  localparam int N     = 1 << BHT_IDX_W;
  localparam int TAG_W = 15 - BHT_IDX_W;

  logic [N-1:0]            valid;
  logic [N-1:0][TAG_W-1:0] tag;
  logic [N-1:0][1:0]       cnt;
  logic [N-1:0][15:0]      tgt;

  logic [BHT_IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0]     l_tag, u_tag;
  logic                 l_hit, u_hit;

  assign l_idx = lookup_pc[BHT_IDX_W:1];
  assign l_tag = lookup_pc[15:BHT_IDX_W+1];
  assign u_idx = upd_pc[BHT_IDX_W:1];
  assign u_tag = upd_pc[15:BHT_IDX_W+1];

  assign l_hit       = valid[l_idx] && (tag[l_idx] == l_tag);
  assign u_hit       = valid[u_idx] && (tag[u_idx] == u_tag);
  assign pred_taken  = l_hit && cnt[l_idx][1];
  assign pred_target = tgt[l_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < N; e++) begin
        valid[e] <= 1'b0;
        tag[e]   <= '0;
        cnt[e]   <= CNT_WNT;
        tgt[e]   <= '0;
      end
    end else if (upd_en) begin
      if (u_hit) begin
        cnt[u_idx] <= cnt_update(cnt[u_idx], upd_taken);
        if (upd_taken) tgt[u_idx] <= upd_target;
      end else if (upd_taken) begin
        // Only taken branches earn an entry; a fresh one starts weakly taken.
        valid[u_idx] <= 1'b1;
        tag[u_idx]   <= u_tag;
        tgt[u_idx]   <= upd_target;
        cnt[u_idx]   <= CNT_WT;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads instruction memory,
// predicts branches, registers IF/ID and handles redirect, stall and HLT.
//   clk, rst_n : clock, async active-low reset
//   fif        : fetch_stage_if.master (imem port, decode feedback, stall,
//                IF/ID outputs, halted)
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          BHT_IDX_W = 3,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master fif
);
  logic [15:0]  pc_q, pc_d, pc_plus2, next_pc, redirect_pc;
  ifid_t        ifid_q, ifid_d, ifid_fetch;
  fetch_state_t state_q, state_d;
  logic         pred_taken, redirect, is_hlt, upd_en;
  logic [15:0]  pred_target;

  assign pc_plus2 = pc_q + 16'd2;
  assign next_pc  = pred_taken ? pred_target : pc_plus2;
  assign is_hlt   = (fif.imem_rdata[15:12] == OP_HLT);
  assign upd_en   = !fif.stall && fif.ID_is_branch;

  // A correct direction with a stale predicted target still needs a redirect.
  assign redirect = upd_en &&
                    (fif.ID_branch_mispredicted ||
                     (fif.ID_branch_taken && ifid_q.pred_taken &&
                      (ifid_q.pred_target != fif.ID_branch_target)));
  assign redirect_pc = fif.ID_branch_taken ? fif.ID_branch_target : ifid_q.pc_next;

  branch_predictor #(.BHT_IDX_W(BHT_IDX_W)) u_bp (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_pc  (pc_q[15:1]),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .upd_en     (upd_en),
    .upd_pc     (ifid_q.pc_curr[15:1]),
    .upd_taken  (fif.ID_branch_taken),
    .upd_target (fif.ID_branch_target)
  );

  always_comb begin
    ifid_fetch.pc_curr     = pc_q;
    ifid_fetch.pc_next     = pc_plus2;
    ifid_fetch.inst        = fif.imem_rdata;
    ifid_fetch.valid       = 1'b1;
    ifid_fetch.pred_taken  = pred_taken && !is_hlt;
    ifid_fetch.pred_target = pred_target;
  end

  always_comb begin
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    state_d = state_q;
    if (!fif.stall) begin
      if (redirect) begin
        // Wrong-path work, including a speculatively fetched HLT, is dropped.
        pc_d        = redirect_pc;
        ifid_d      = '0;
        ifid_d.inst = BUBBLE_INST;
        state_d     = ST_RUN;
      end else if (state_q == ST_HALT) begin
        ifid_d      = '0;
        ifid_d.inst = BUBBLE_INST;
      end else begin
        ifid_d = ifid_fetch;
        if (is_hlt) state_d = ST_HALT;
        else        pc_d    = next_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      ifid_q      <= '0;
      ifid_q.inst <= BUBBLE_INST;
      state_q     <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      state_q <= state_d;
    end
  end

  assign fif.imem_addr              = pc_q;
  assign fif.IF_ID_pc_curr          = ifid_q.pc_curr;
  assign fif.IF_ID_pc_next          = ifid_q.pc_next;
  assign fif.IF_ID_inst             = ifid_q.inst;
  assign fif.IF_ID_valid            = ifid_q.valid;
  assign fif.IF_ID_predicted_taken  = ifid_q.pred_taken;
  assign fif.IF_ID_predicted_target = ifid_q.pred_target;
  assign fif.halted                 = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a word-array imem model driven by the
// PC, and tasks acting as decode that resolve branches on request.
module tb_fetch_stage;
  localparam logic [15:0] W_NOP = 16'h0123;
  localparam logic [15:0] W_B   = 16'hC000;
  localparam logic [15:0] W_HLT = 16'hF000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] mem [256];
  int n_checks = 0;
  int n_fail = 0;

  fetch_stage_if ifc();
  fetch_stage #(.BHT_IDX_W(3), .RESET_PC(16'h0000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .fif  (ifc)
  );

  always #5 clk = ~clk;
  assign ifc.imem_rdata = mem[ifc.imem_addr[8:1]];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_id();
    ifc.ID_is_branch = 1'b0; ifc.ID_branch_taken = 1'b0;
    ifc.ID_branch_mispredicted = 1'b0; ifc.ID_branch_target = 16'h0000;
  endtask

  task automatic set_mem(input logic [15:0] a, input logic [15:0] d);
    mem[a[8:1]] = d;
  endtask

  // Decode resolves the instruction now in IF/ID.
  task automatic resolve(input logic taken, input logic [15:0] tgt);
    ifc.ID_is_branch = 1'b1;
    ifc.ID_branch_taken = taken;
    ifc.ID_branch_mispredicted = (taken != ifc.IF_ID_predicted_taken);
    ifc.ID_branch_target = tgt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ifc.stall = 1'b0; clear_id();
    for (int i = 0; i < 256; i++) mem[i] = W_NOP;
    #2; @(posedge clk); #3; rst_n = 1'b1;
  endtask

  task automatic run_to(input logic [15:0] pc);
    bit found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (ifc.IF_ID_valid === 1'b1 && ifc.IF_ID_pc_curr === pc) found = 1'b1;
      else tick();
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL run_to: IF_ID_pc_curr=%h never reached %h", ifc.IF_ID_pc_curr, pc); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ifc.stall = 1'b0; clear_id();
    for (int i = 0; i < 256; i++) mem[i] = W_NOP;
    #2;
    n_checks++; if (ifc.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h want 0000", ifc.imem_addr); end
    n_checks++; if (ifc.IF_ID_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ifc.IF_ID_valid); end
    n_checks++; if (ifc.IF_ID_inst !== 16'h0000) begin n_fail++; $display("FAIL reset_inst: got %h want 0000", ifc.IF_ID_inst); end
    n_checks++; if (ifc.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", ifc.halted); end
    @(posedge clk); #3; rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (ifc.IF_ID_pc_curr !== 16'(2*k)) begin n_fail++; $display("FAIL seq_pc_curr[%0d]: got %h want %h", k, ifc.IF_ID_pc_curr, 16'(2*k)); end
      n_checks++; if (ifc.IF_ID_pc_next !== 16'(2*k+2)) begin n_fail++; $display("FAIL seq_pc_next[%0d]: got %h want %h", k, ifc.IF_ID_pc_next, 16'(2*k+2)); end
      n_checks++; if ({ifc.IF_ID_valid, ifc.IF_ID_predicted_taken} !== 2'b10) begin n_fail++; $display("FAIL seq_valid_pred[%0d]: got %b%b want 10", k, ifc.IF_ID_valid, ifc.IF_ID_predicted_taken); end
      n_checks++; if (ifc.IF_ID_inst !== W_NOP) begin n_fail++; $display("FAIL seq_inst[%0d]: got %h want %h", k, ifc.IF_ID_inst, W_NOP); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    resolve(1'b1, 16'hFFFE); tick(); clear_id();
    n_checks++; if (ifc.imem_addr !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_redirect: got %h want fffe", ifc.imem_addr); end
    tick();
    n_checks++; if (ifc.IF_ID_pc_next !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc_next: got %h want 0000", ifc.IF_ID_pc_next); end
    n_checks++; if (ifc.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc: got %h want 0000", ifc.imem_addr); end
  endtask

  task automatic test_branch_predict();
    do_reset();
    set_mem(16'h0010, W_B); set_mem(16'h0042, W_B);
    run_to(16'h0010);
    n_checks++; if (ifc.IF_ID_predicted_taken !== 1'b0) begin n_fail++; $display("FAIL first_pred: got %b want 0", ifc.IF_ID_predicted_taken); end
    resolve(1'b1, 16'h0040); tick(); clear_id();
    n_checks++; if ({ifc.imem_addr, ifc.IF_ID_valid} !== {16'h0040, 1'b0}) begin n_fail++; $display("FAIL first_redirect: got pc %h valid %b want 0040 0", ifc.imem_addr, ifc.IF_ID_valid); end
    run_to(16'h0042);
    resolve(1'b1, 16'h0010); tick(); clear_id();
    run_to(16'h0010);
    n_checks++; if ({ifc.IF_ID_predicted_taken, ifc.IF_ID_predicted_target} !== {1'b1, 16'h0040}) begin n_fail++; $display("FAIL second_pred: got %b %h want 1 0040", ifc.IF_ID_predicted_taken, ifc.IF_ID_predicted_target); end
    n_checks++; if (ifc.imem_addr !== 16'h0040) begin n_fail++; $display("FAIL second_next_pc: got %h want 0040", ifc.imem_addr); end
    resolve(1'b1, 16'h0040); tick(); clear_id();
    n_checks++; if ({ifc.IF_ID_pc_curr, ifc.IF_ID_valid} !== {16'h0040, 1'b1}) begin n_fail++; $display("FAIL second_no_bubble: got %h %b want 0040 1", ifc.IF_ID_pc_curr, ifc.IF_ID_valid); end
    // Direction right, target wrong: still redirected.
    run_to(16'h0042);
    resolve(1'b1, 16'h0010); tick(); clear_id();
    run_to(16'h0010);
    resolve(1'b1, 16'h0060); tick(); clear_id();
    n_checks++; if ({ifc.imem_addr, ifc.IF_ID_valid} !== {16'h0060, 1'b0}) begin n_fail++; $display("FAIL target_mismatch: got pc %h valid %b want 0060 0", ifc.imem_addr, ifc.IF_ID_valid); end
  endtask

  task automatic test_not_taken();
    do_reset();
    set_mem(16'h0010, W_B); set_mem(16'h0014, W_B); set_mem(16'h0042, W_B);
    run_to(16'h0010);
    resolve(1'b1, 16'h0040); tick(); clear_id();
    run_to(16'h0042);
    resolve(1'b1, 16'h0010); tick(); clear_id();
    run_to(16'h0010);
    n_checks++; if (ifc.IF_ID_predicted_taken !== 1'b1) begin n_fail++; $display("FAIL nt_pred_wt: got %b want 1", ifc.IF_ID_predicted_taken); end
    resolve(1'b0, 16'h0040); tick(); clear_id();
    n_checks++; if ({ifc.imem_addr, ifc.IF_ID_valid} !== {16'h0012, 1'b0}) begin n_fail++; $display("FAIL nt_redirect: got pc %h valid %b want 0012 0", ifc.imem_addr, ifc.IF_ID_valid); end
    run_to(16'h0014);
    resolve(1'b1, 16'h0010); tick(); clear_id();
    run_to(16'h0010);
    n_checks++; if (ifc.IF_ID_predicted_taken !== 1'b0) begin n_fail++; $display("FAIL nt_pred_wnt: got %b want 0", ifc.IF_ID_predicted_taken); end
    resolve(1'b0, 16'h0040); tick(); clear_id();
    n_checks++; if ({ifc.IF_ID_pc_curr, ifc.IF_ID_valid} !== {16'h0012, 1'b1}) begin n_fail++; $display("FAIL nt_no_bubble: got %h %b want 0012 1", ifc.IF_ID_pc_curr, ifc.IF_ID_valid); end
    run_to(16'h0014);
    n_checks++; if (ifc.IF_ID_predicted_taken !== 1'b1) begin n_fail++; $display("FAIL loop_pred: got %b want 1", ifc.IF_ID_predicted_taken); end
    resolve(1'b1, 16'h0010); tick(); clear_id();
    run_to(16'h0010);
    n_checks++; if (ifc.IF_ID_predicted_taken !== 1'b0) begin n_fail++; $display("FAIL nt_pred_snt: got %b want 0", ifc.IF_ID_predicted_taken); end
  endtask

  task automatic test_stall();
    do_reset();
    set_mem(16'h0010, W_B);
    run_to(16'h0010);
    resolve(1'b1, 16'h0040); ifc.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if ({ifc.imem_addr, ifc.IF_ID_pc_curr, ifc.IF_ID_valid} !== {16'h0012, 16'h0010, 1'b1}) begin n_fail++; $display("FAIL stall_hold[%0d]: got pc %h ifid %h valid %b want 0012 0010 1", k, ifc.imem_addr, ifc.IF_ID_pc_curr, ifc.IF_ID_valid); end
    end
    ifc.stall = 1'b0; tick(); clear_id();
    n_checks++; if ({ifc.imem_addr, ifc.IF_ID_valid} !== {16'h0040, 1'b0}) begin n_fail++; $display("FAIL stall_release: got pc %h valid %b want 0040 0", ifc.imem_addr, ifc.IF_ID_valid); end
  endtask

  task automatic test_halt();
    do_reset();
    set_mem(16'h0020, W_HLT);
    run_to(16'h0020);
    n_checks++; if ({ifc.IF_ID_inst, ifc.IF_ID_predicted_taken, ifc.halted} !== {W_HLT, 1'b0, 1'b1}) begin n_fail++; $display("FAIL hlt_enter: got inst %h pred %b halted %b want f000 0 1", ifc.IF_ID_inst, ifc.IF_ID_predicted_taken, ifc.halted); end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++; if ({ifc.imem_addr, ifc.IF_ID_valid, ifc.IF_ID_inst, ifc.halted} !== {16'h0020, 1'b0, 16'h0000, 1'b1}) begin n_fail++; $display("FAIL hlt_hold[%0d]: got pc %h valid %b inst %h halted %b want 0020 0 0000 1", k, ifc.imem_addr, ifc.IF_ID_valid, ifc.IF_ID_inst, ifc.halted); end
    end
  endtask

  task automatic test_halt_cancel();
    do_reset();
    set_mem(16'h001E, W_B); set_mem(16'h0020, W_HLT);
    run_to(16'h001E);
    resolve(1'b1, 16'h0040); tick(); clear_id();
    n_checks++; if ({ifc.halted, ifc.imem_addr, ifc.IF_ID_valid} !== {1'b0, 16'h0040, 1'b0}) begin n_fail++; $display("FAIL shadow_hlt: got halted %b pc %h valid %b want 0 0040 0", ifc.halted, ifc.imem_addr, ifc.IF_ID_valid); end
    tick();
    n_checks++; if ({ifc.IF_ID_pc_curr, ifc.IF_ID_valid, ifc.halted} !== {16'h0040, 1'b1, 1'b0}) begin n_fail++; $display("FAIL shadow_resume: got %h %b %b want 0040 1 0", ifc.IF_ID_pc_curr, ifc.IF_ID_valid, ifc.halted); end
    // Already halted, then a redirect arrives: halt must clear.
    do_reset();
    set_mem(16'h0020, W_HLT);
    run_to(16'h0020); tick();
    resolve(1'b1, 16'h0030); tick(); clear_id();
    n_checks++; if ({ifc.halted, ifc.imem_addr} !== {1'b0, 16'h0030}) begin n_fail++; $display("FAIL halted_redirect: got halted %b pc %h want 0 0030", ifc.halted, ifc.imem_addr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_mem(16'h0010, W_B);
    run_to(16'h0010);
    resolve(1'b1, 16'h0040); tick(); clear_id();
    run_to(16'h0040); tick(); tick();
    #3; rst_n = 1'b0; #1;
    n_checks++; if ({ifc.imem_addr, ifc.IF_ID_pc_curr, ifc.IF_ID_inst} !== 48'h0) begin n_fail++; $display("FAIL async_rst_regs: got pc %h ifid %h inst %h want 0", ifc.imem_addr, ifc.IF_ID_pc_curr, ifc.IF_ID_inst); end
    n_checks++; if ({ifc.IF_ID_valid, ifc.IF_ID_predicted_taken, ifc.halted} !== 3'b000) begin n_fail++; $display("FAIL async_rst_flags: got %b%b%b want 000", ifc.IF_ID_valid, ifc.IF_ID_predicted_taken, ifc.halted); end
    @(posedge clk); #3; rst_n = 1'b1;
    run_to(16'h0010);
    n_checks++; if (ifc.IF_ID_predicted_taken !== 1'b0) begin n_fail++; $display("FAIL async_rst_bht: got %b want 0", ifc.IF_ID_predicted_taken); end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_branch_predict();
    test_not_taken();
    test_stall();
    test_halt();
    test_halt_cancel();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of the decode stage: owns the PC, drives instruction memory, predicts branches dynamically, and registers the IF/ID pipeline outputs that decode consumes.
- Decode sends back branch direction, target and misprediction status; this block trains its predictor with them and redirects the PC.
- Pipeline flushes, stalls and HLT hold are resolved here.

Parameters:
BHT_IDX_W, 3, log2 of predictor entries (8 entries); index = PC[BHT_IDX_W:1]
RESET_PC, 16'h0000, PC value after reset

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  hazard-unit stall; freezes PC, IF/ID and predictor
imem_addr  output  16  instruction memory address (= PC), combinational read
imem_rdata  input  16  instruction word at imem_addr, same cycle
ID_is_branch  input  1  instruction in decode is B/BR
ID_branch_taken  input  1  decode-resolved direction
ID_branch_mispredicted  input  1  decode direction mismatch vs IF_ID_predicted_taken
ID_branch_target  input  16  decode-resolved target
IF_ID_pc_curr  output  16  PC of instruction in IF/ID
IF_ID_pc_next  output  16  IF_ID_pc_curr + 2
IF_ID_inst  output  16  instruction word
IF_ID_valid  output  1  0 = bubble; downstream gates RegWrite/MemWrite/flag enables
IF_ID_predicted_taken  output  1  prediction made at fetch
IF_ID_predicted_target  output  16  predicted target (valid when predicted_taken)
halted  output  1  HLT fetched; PC frozen

Behaviour:
- Reset (async, rst_n=0): PC=RESET_PC; IF_ID_inst=16'h0000, IF_ID_valid=0, all other IF_ID_* =0; halted=0; every BHT entry valid=0, counter=2'b01, tag/target=0.
- Predictor entry: valid, tag=PC[15:BHT_IDX_W+1], 2-bit counter, 16-bit target. Lookup is combinational on PC: hit = valid & tag match; pred_taken = hit & counter[1]; pred_target = entry target.
- Next PC (normal): pred_taken ? pred_target : PC+2 (16-bit wrap, 16'hFFFE+2 = 16'h0000).
- Update (rising edge, only when ~stall and ID_is_branch), indexed/tagged by IF_ID_pc_curr: on hit, counter saturating +1 if taken, −1 if not taken; target overwritten when taken. On miss and taken: allocate valid=1, tag, target, counter=2'b10. On miss and not taken: no change.
- Redirect condition (computed internally): ~stall & ID_is_branch & (ID_branch_mispredicted | (ID_branch_taken & IF_ID_predicted_taken & IF_ID_predicted_target != ID_branch_target)). Redirect PC = ID_branch_taken ? ID_branch_target : IF_ID_pc_next.
- Priority per edge: stall > redirect > halted > normal.
  - stall=1: PC, IF/ID, halted and BHT hold; redirect/update ignored (decode result invalid while stalled).
  - redirect: PC <= redirect PC; IF/ID <= bubble (inst 0, valid 0, pred 0); halted <= 0 (HLT in wrong-path shadow is cancelled). BHT update still applies.
  - halted=1: PC holds; IF/ID <= bubble.
  - normal: PC <= next PC; IF/ID <= {PC, PC+2, imem_rdata, valid 1, pred_taken, pred_target}; if imem_rdata[15:12]==4'hF (HLT), PC <= PC (not next PC) and halted <= 1; HLT itself enters IF/ID once with valid=1 and pred_taken forced 0.
- Latency: instruction fetched at cycle N appears on IF_ID_* after the edge ending cycle N (1 cycle). Misprediction penalty: 1 bubble.
- Predictor read and update on the same index in the same cycle: read returns the pre-update value.

Decomposition:
- Shared package: opcode constants (OP_B=4'hC, OP_BR=4'hD, OP_HLT=4'hF), BUBBLE_INST=16'h0000, counter encodings (SNT=00, WNT=01, WT=10, ST=11).
- One sub-module: branch_predictor (BHT/BTB storage, combinational lookup, saturating update); fetch_stage holds PC, redirect/halt control and IF/ID register.

Test Plan:
- Reset release, imem returns 16'h0123 at every address, no branches -> IF_ID_pc_curr 0,2,4,... one per cycle, valid=1, predicted_taken=0.
- B at 16'h0010 taken to 16'h0040, first encounter -> IF_ID_predicted_taken=0, redirect, PC=16'h0040 next cycle, one bubble; second encounter -> predicted_taken=1, predicted_target=16'h0040, no bubble.
- Same branch then not taken twice -> counter 10->01->00; third fetch predicts not taken; a not-taken mispredict redirects PC to 16'h0012.
- stall=1 for 3 cycles during a mispredicted branch in decode -> PC, IF/ID, BHT unchanged; redirect occurs on the first edge after stall drops.
- HLT (16'hF000) at 16'h0020 -> IF/ID holds HLT once, then bubbles; halted=1, PC stays 16'h0020.
- Mispredicted branch at 16'h001E with HLT at 16'h0020 on the wrong path -> halted cleared, PC = branch target, fetch resumes.
- Assert rst_n low mid-run, asynchronously between edges -> all outputs return to reset values immediately; BHT cleared.
